alu_decode_issue: RTL and testbench
===================================

# alu_decode_issue

Registered instruction-to-ALU decode stage that drives the 4-bit ALU control code, operand selects and immediate consumed by the 32-bit ALU. It sits between instruction fetch/register read and the execute stage. It accepts one MIPS instruction per cycle over a valid/ready handshake and presents the decoded bundle one cycle later. A one-entry skid buffer keeps `InReady` a registered signal.

## Interface
- `CNT_W`, 16, width of the handed-off instruction counter
- `Clk`  in  1  clock; all state updates on rising edge
- `Rst`  in  1  synchronous, active-high reset
- `Flush`  in  1  synchronous; drops all buffered and in-flight decodes
- `InValid`  in  1  `Instr` is valid
- `InReady`  out  1  stage can accept (registered)
- `Instr`  in  32  MIPS instruction word
- `OutValid`  out  1  decoded bundle valid
- `OutReady`  in  1  execute stage consumes bundle
- `ALUControl`  out  4  ALU operation code
- `ASel`  out  1  0 = rs, 1 = rt
- `BSel`  out  2  0 = rt, 1 = ImmOut, 2 = shamt, 3 = ImmOut constant
- `ImmOut`  out  32  extended immediate or constant
- `Illegal`  out  1  instruction not decodable
- `DecodeCount`  out  CNT_W  count of bundles handed off (OutValid & OutReady), wraps

## Operation
- ALU codes: AND 0, OR 1, ADD 2, NOR 3, XOR 4, SUB 6, SLT 7, JUMP 8, MUL 9, SLL 10, SGT 11, CLO/CLZ 12, ROTR 13, SLTU 14.
- Decode when op = 0x00 (ASel 0, BSel 0 unless noted):
  - funct 0x20/0x21 → 2
  - 0x22/0x23 → 6
  - 0x24 → 0
  - 0x25 → 1
  - 0x26 → 4
  - 0x27 → 3
  - 0x2A → 7
  - 0x2B → 14
  - 0x08 (jr) → 8
  - 0x00 (sll) → 10, ASel 1, BSel 2, ImmOut = {27'b0, shamt}
  - 0x02 with Instr[21] = 1 (rotr) → 13, ASel 1, BSel 2, ImmOut = shamt
  - Any other funct is illegal.
- Decode when op = 0x1C:
  - funct 0x02 → 9
  - 0x20 (clz) → 12, BSel 3, ImmOut 0
  - 0x21 (clo) → 12, BSel 3, ImmOut 1
- I-type, BSel 1:
  - addi 0x08, addiu 0x09, lw 0x23, sw 0x2B → 2, sign-extended
  - slti 0x0A → 7, sign-extended
  - sltiu 0x0B → 14, sign-extended
  - andi 0x0C → 0, zero-extended
  - ori 0x0D → 1, zero-extended
  - xori 0x0E → 4, zero-extended
- beq 0x04 / bne 0x05 → 6, BSel 0.
- j 0x02 / jal 0x03 → 8, BSel 3, ImmOut 0.
- Illegal instruction: bundle is still issued with ALUControl 8, ASel 0, BSel 3, ImmOut 0, Illegal 1.
- Storage: output register (main) plus one skid entry.
  - Accept = InValid & InReady.
  - Accept with main empty, or main handing off with skid empty: decode goes straight to main.
  - Accept while main is full and not handing off: decode goes to skid.
  - On main handoff with skid full: skid moves to main.
  - InReady next = skid empty next cycle.
- DecodeCount increments by 1 on each OutValid & OutReady cycle. It wraps from 2^CNT_W−1 to 0 and is not affected by Flush.

## Timing
- Reset values: OutValid 0, InReady 1, ALUControl 0, ASel 0, BSel 0, ImmOut 0, Illegal 0, DecodeCount 0, skid empty.
- Latency: instruction accepted in cycle N gives OutValid in cycle N+1.
- Throughput: 1 per cycle with OutReady held high.
- Output stability: bundle fields hold stable while OutValid & !OutReady.
- InReady drops the cycle after the skid fills. It rises the cycle after the skid drains.
- Flush in cycle N: main and skid are invalid at N+1. An accept in cycle N is discarded. InReady = 1 at N+1. A handoff in the same cycle as Flush still counts.
- Flush with Rst: Rst wins, and DecodeCount resets.
- Rst mid-stream: all state returns to reset values next edge; nothing is issued afterward.

## Test plan
- Reset then add $3,$1,$2 (0x00221820) with OutReady = 1 → next cycle: OutValid 1, ALUControl 2, ASel 0, BSel 0, Illegal 0, DecodeCount increments to 1.
- addi (0x2021FFFC) → ImmOut 0xFFFFFFFC, BSel 1, ALUControl 2. andi (0x3021FFFC) → ImmOut 0x0000FFFC, ALUControl 0.
- sll shamt 5 (0x00021940) → ALUControl 10, ASel 1, BSel 2, ImmOut 5. rotr shamt 5 (0x00221942) → ALUControl 13. clo (0x70201821) → ALUControl 12, BSel 3, ImmOut 1.
- Stream 3 instructions with OutReady = 0 → first two accepted, InReady 0 after the second, first bundle held stable. Raise OutReady → bundles issued in order, InReady back to 1.
- Flush while main and skid are full with InValid = 1 → OutValid 0 next cycle, DecodeCount unchanged, the instruction offered in the flush cycle is never issued.
- Opcode 0x3F → Illegal 1, ALUControl 8. Then issue 2^CNT_W handoffs (CNT_W = 4 build) → DecodeCount wraps to 0.

Source files
------------

// File: rtl/alu_decode_issue.sv
// Registered MIPS instruction-to-ALU decode stage with valid/ready handshake.
// A one-entry skid buffer behind the output register keeps InReady registered.
module alu_decode_issue #(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Flush,
  input  logic             InValid,
  output logic             InReady,
  input  logic [31:0]      Instr,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [3:0]       ALUControl,
  output logic             ASel,
  output logic [1:0]       BSel,
  output logic [31:0]      ImmOut,
  output logic             Illegal,
  output logic [CNT_W-1:0] DecodeCount
);

  typedef struct packed {
    logic [3:0]  alu;
    logic        asel;
    logic [1:0]  bsel;
    logic [31:0] imm;
    logic        illegal;
  } bundle_t;

  localparam bundle_t BUNDLE_ZERO = '0;

  function automatic bundle_t mk(input logic [3:0] alu, input logic asel,
                                 input logic [1:0] bsel, input logic [31:0] imm);
    bundle_t b;
    b.alu     = alu;
    b.asel    = asel;
    b.bsel    = bsel;
    b.imm     = imm;
    b.illegal = 1'b0;
    return b;
  endfunction

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] sext;
  logic [31:0] zext;
  logic        unused_instr_bits;

  assign op    = Instr[31:26];
  assign funct = Instr[5:0];
  assign shamt = Instr[10:6];
  assign sext  = {{16{Instr[15]}}, Instr[15:0]};
  assign zext  = {16'b0, Instr[15:0]};
  // Register specifiers are consumed by the register file, not by this stage.
  assign unused_instr_bits = ^{Instr[25:22], Instr[20:16]};

  bundle_t dec;

  always_comb begin
    // Undecodable words still issue as a harmless JUMP-coded bundle flagged illegal.
    dec         = mk(4'd8, 1'b0, 2'd3, 32'd0);
    dec.illegal = 1'b1;
    case (op)
      6'h00: begin
        case (funct)
          6'h20, 6'h21: dec = mk(4'd2,  1'b0, 2'd0, 32'd0);
          6'h22, 6'h23: dec = mk(4'd6,  1'b0, 2'd0, 32'd0);
          6'h24:        dec = mk(4'd0,  1'b0, 2'd0, 32'd0);
          6'h25:        dec = mk(4'd1,  1'b0, 2'd0, 32'd0);
          6'h26:        dec = mk(4'd4,  1'b0, 2'd0, 32'd0);
          6'h27:        dec = mk(4'd3,  1'b0, 2'd0, 32'd0);
          6'h2A:        dec = mk(4'd7,  1'b0, 2'd0, 32'd0);
          6'h2B:        dec = mk(4'd14, 1'b0, 2'd0, 32'd0);
          6'h08:        dec = mk(4'd8,  1'b0, 2'd0, 32'd0);
          6'h00:        dec = mk(4'd10, 1'b1, 2'd2, {27'b0, shamt});
          6'h02: begin
            if (Instr[21]) dec = mk(4'd13, 1'b1, 2'd2, {27'b0, shamt});
          end
          default: ;
        endcase
      end
      6'h1C: begin
        case (funct)
          6'h02:   dec = mk(4'd9,  1'b0, 2'd0, 32'd0);
          6'h20:   dec = mk(4'd12, 1'b0, 2'd3, 32'd0);
          6'h21:   dec = mk(4'd12, 1'b0, 2'd3, 32'd1);
          default: ;
        endcase
      end
      6'h08, 6'h09, 6'h23, 6'h2B: dec = mk(4'd2,  1'b0, 2'd1, sext);
      6'h0A:                      dec = mk(4'd7,  1'b0, 2'd1, sext);
      6'h0B:                      dec = mk(4'd14, 1'b0, 2'd1, sext);
      6'h0C:                      dec = mk(4'd0,  1'b0, 2'd1, zext);
      6'h0D:                      dec = mk(4'd1,  1'b0, 2'd1, zext);
      6'h0E:                      dec = mk(4'd4,  1'b0, 2'd1, zext);
      6'h04, 6'h05:               dec = mk(4'd6,  1'b0, 2'd0, 32'd0);
      6'h02, 6'h03:               dec = mk(4'd8,  1'b0, 2'd3, 32'd0);
      default: ;
    endcase
  end

  bundle_t          main_reg, main_next;
  bundle_t          skid_reg, skid_next;
  logic             main_valid_reg, main_valid_next;
  logic             skid_valid_reg, skid_valid_next;
  logic             in_ready_reg;
  logic [CNT_W-1:0] count_reg;
  logic             accept;
  logic             handoff;

  assign accept  = InValid & in_ready_reg;
  assign handoff = main_valid_reg & OutReady;

  always_comb begin
    main_next       = main_reg;
    skid_next       = skid_reg;
    main_valid_next = main_valid_reg;
    skid_valid_next = skid_valid_reg;
    if (Flush) begin
      main_valid_next = 1'b0;
      skid_valid_next = 1'b0;
    end else if (handoff) begin
      // A full skid deasserts InReady, so accept cannot coincide with a skid refill.
      if (skid_valid_reg) begin
        main_next       = skid_reg;
        skid_valid_next = 1'b0;
      end else if (accept) begin
        main_next = dec;
      end
      main_valid_next = skid_valid_reg | accept;
    end else if (accept) begin
      if (main_valid_reg) begin
        skid_next       = dec;
        skid_valid_next = 1'b1;
      end else begin
        main_next       = dec;
        main_valid_next = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      main_reg       <= BUNDLE_ZERO;
      skid_reg       <= BUNDLE_ZERO;
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
      in_ready_reg   <= 1'b1;
      count_reg      <= '0;
    end else begin
      main_reg       <= main_next;
      skid_reg       <= skid_next;
      main_valid_reg <= main_valid_next;
      skid_valid_reg <= skid_valid_next;
      in_ready_reg   <= ~skid_valid_next;
      if (handoff) count_reg <= count_reg + 1'b1;
    end
  end

  assign InReady     = in_ready_reg;
  assign OutValid    = main_valid_reg;
  assign ALUControl  = main_reg.alu;
  assign ASel        = main_reg.asel;
  assign BSel        = main_reg.bsel;
  assign ImmOut      = main_reg.imm;
  assign Illegal     = main_reg.illegal;
  assign DecodeCount = count_reg;

endmodule

// File: tb/tb_alu_decode_issue.sv
// Scoreboard bench for alu_decode_issue: hand-written expected bundles are queued
// on accept and compared on every handoff.
module tb_alu_decode_issue;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       alu_control;
  logic             a_sel;
  logic [1:0]       b_sel;
  logic [31:0]      imm_out;
  logic             illegal;
  logic [CNT_W-1:0] decode_count;

  alu_decode_issue #(.CNT_W(CNT_W)) dut (
    .Clk(clk), .Rst(rst), .Flush(flush),
    .InValid(in_valid), .InReady(in_ready), .Instr(instr),
    .OutValid(out_valid), .OutReady(out_ready),
    .ALUControl(alu_control), .ASel(a_sel), .BSel(b_sel),
    .ImmOut(imm_out), .Illegal(illegal), .DecodeCount(decode_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  alu;
    logic        asel;
    logic [1:0]  bsel;
    logic [31:0] imm;
    bit          imm_care;
    logic        ill;
  } exp_t;

  exp_t tbl[$];
  exp_t sb_q[$];
  exp_t cur_exp;
  int   checks = 0;
  int   errors = 0;
  int   exp_count = 0;
  int   issued = 0;
  bit   last_acc;
  int   last_tries;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] i, input logic [3:0] a, input logic as,
                              input logic [1:0] bs, input logic [31:0] im, input bit care,
                              input logic il);
    exp_t e;
    e.instr = i; e.alu = a; e.asel = as; e.bsel = bs; e.imm = im; e.imm_care = care; e.ill = il;
    return e;
  endfunction

  // Called at the negedge: scores the handshakes of the coming edge, then advances one cycle.
  task automatic tick();
    bit acc, hs;
    exp_t e;
    acc = in_valid && in_ready;
    hs  = out_valid && out_ready;
    if (rst) begin
      sb_q.delete();
      exp_count = 0;
    end else begin
      if (hs) begin
        exp_count++;
        if (sb_q.size() == 0) begin
          check("spurious_issue", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          issued++;
          $display("issue %0d: instr=%08h alu=%0d asel=%0d bsel=%0d imm=%08h ill=%0d",
                   issued, e.instr, alu_control, a_sel, b_sel, imm_out, illegal);
          check("alu", {28'd0, alu_control}, {28'd0, e.alu});
          check("asel", {31'd0, a_sel}, {31'd0, e.asel});
          check("bsel", {30'd0, b_sel}, {30'd0, e.bsel});
          check("illegal", {31'd0, illegal}, {31'd0, e.ill});
          if (e.imm_care) check("imm", imm_out, e.imm);
        end
      end
      if (flush) sb_q.delete();
      else if (acc) sb_q.push_back(cur_exp);
    end
    last_acc = acc && !rst && !flush;
    @(posedge clk);
    @(negedge clk);
    check("count", {28'd0, decode_count}, exp_count % (1 << CNT_W));
  endtask

  task automatic send(input exp_t e);
    cur_exp    = e;
    instr      = e.instr;
    in_valid   = 1'b1;
    last_acc   = 1'b0;
    last_tries = 0;
    while (!last_acc && last_tries < 10) begin
      tick();
      last_tries++;
    end
    if (!last_acc) check("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && (sb_q.size() > 0 || out_valid); i++) tick();
    check("drain_empty", sb_q.size(), 32'd0);
    check("drain_outvalid", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    tbl.push_back(mk(32'h00221820, 4'd2,  1'b0, 2'd0, 32'h0,        1'b0, 1'b0)); // add
    tbl.push_back(mk(32'h2021FFFC, 4'd2,  1'b0, 2'd1, 32'hFFFFFFFC, 1'b1, 1'b0)); // addi
    tbl.push_back(mk(32'h3021FFFC, 4'd0,  1'b0, 2'd1, 32'h0000FFFC, 1'b1, 1'b0)); // andi
    tbl.push_back(mk(32'h00021940, 4'd10, 1'b1, 2'd2, 32'd5,        1'b1, 1'b0)); // sll 5
    tbl.push_back(mk(32'h00221942, 4'd13, 1'b1, 2'd2, 32'd5,        1'b1, 1'b0)); // rotr 5
    tbl.push_back(mk(32'h70201821, 4'd12, 1'b0, 2'd3, 32'd1,        1'b1, 1'b0)); // clo
    tbl.push_back(mk(32'h70201820, 4'd12, 1'b0, 2'd3, 32'd0,        1'b1, 1'b0)); // clz
    tbl.push_back(mk(32'h70221802, 4'd9,  1'b0, 2'd0, 32'h0,        1'b0, 1'b0)); // mul
    tbl.push_back(mk(32'h00221822, 4'd6,  1'b0, 2'd0, 32'h0,        1'b0, 1'b0)); // sub
    tbl.push_back(mk(32'h00221825, 4'd1,  1'b0, 2'd0, 32'h0,        1'b0, 1'b0)); // or
    tbl.push_back(mk(32'h00221826, 4'd4,  1'b0, 2'd0, 32'h0,        1'b0, 1'b0)); // xor
    tbl.push_back(mk(32'h00221827, 4'd3,  1'b0, 2'd0, 32'h0,        1'b0, 1'b0)); // nor
    tbl.push_back(mk(32'h0022182A, 4'd7,  1'b0, 2'd0, 32'h0,        1'b0, 1'b0)); // slt
    tbl.push_back(mk(32'h0022182B, 4'd14, 1'b0, 2'd0, 32'h0,        1'b0, 1'b0)); // sltu
    tbl.push_back(mk(32'h03E00008, 4'd8,  1'b0, 2'd0, 32'h0,        1'b0, 1'b0)); // jr
    tbl.push_back(mk(32'h28218000, 4'd7,  1'b0, 2'd1, 32'hFFFF8000, 1'b1, 1'b0)); // slti
    tbl.push_back(mk(32'h2C210001, 4'd14, 1'b0, 2'd1, 32'h00000001, 1'b1, 1'b0)); // sltiu
    tbl.push_back(mk(32'h3421ABCD, 4'd1,  1'b0, 2'd1, 32'h0000ABCD, 1'b1, 1'b0)); // ori
    tbl.push_back(mk(32'h38218001, 4'd4,  1'b0, 2'd1, 32'h00008001, 1'b1, 1'b0)); // xori
    tbl.push_back(mk(32'h8C22FFF0, 4'd2,  1'b0, 2'd1, 32'hFFFFFFF0, 1'b1, 1'b0)); // lw
    tbl.push_back(mk(32'hAC220010, 4'd2,  1'b0, 2'd1, 32'h00000010, 1'b1, 1'b0)); // sw
    tbl.push_back(mk(32'h10220003, 4'd6,  1'b0, 2'd0, 32'h0,        1'b0, 1'b0)); // beq
    tbl.push_back(mk(32'h08000010, 4'd8,  1'b0, 2'd3, 32'd0,        1'b1, 1'b0)); // j
    tbl.push_back(mk(32'h0C000010, 4'd8,  1'b0, 2'd3, 32'd0,        1'b1, 1'b0)); // jal
    tbl.push_back(mk(32'hFC000000, 4'd8,  1'b0, 2'd3, 32'd0,        1'b1, 1'b1)); // op 0x3F
    tbl.push_back(mk(32'h00000001, 4'd8,  1'b0, 2'd3, 32'd0,        1'b1, 1'b1)); // bad funct
    tbl.push_back(mk(32'h00021942, 4'd8,  1'b0, 2'd3, 32'd0,        1'b1, 1'b1)); // srl, not rotr
    tbl.push_back(mk(32'h70000003, 4'd8,  1'b0, 2'd3, 32'd0,        1'b1, 1'b1)); // bad 0x1C funct

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = '0;
    cur_exp = tbl[0];
    @(negedge clk);
    tick(); tick();
    rst = 1'b0;
    check("rst_outvalid", {31'd0, out_valid}, 32'd0);
    check("rst_inready", {31'd0, in_ready}, 32'd1);
    check("rst_alu", {28'd0, alu_control}, 32'd0);
    check("rst_asel", {31'd0, a_sel}, 32'd0);
    check("rst_bsel", {30'd0, b_sel}, 32'd0);
    check("rst_imm", imm_out, 32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    check("rst_count", {28'd0, decode_count}, 32'd0);

    // Full decode table back-to-back, one per cycle.
    out_ready = 1'b1;
    send(tbl[0]);
    check("latency_outvalid", {31'd0, out_valid}, 32'd1);
    for (int i = 1; i < tbl.size(); i++) begin
      send(tbl[i]);
      check("throughput", last_tries, 32'd1);
    end
    drain();

    // Backpressure: main then skid fill, third word must wait.
    out_ready = 1'b0;
    send(tbl[1]);
    check("bp_inready_1", {31'd0, in_ready}, 32'd1);
    send(tbl[3]);
    check("bp_inready_0", {31'd0, in_ready}, 32'd0);
    cur_exp = tbl[5]; instr = tbl[5].instr; in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("bp_not_accepted", {31'd0, last_acc}, 32'd0);
      check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      check("bp_hold_alu", {28'd0, alu_control}, {28'd0, sb_q[0].alu});
      check("bp_hold_imm", imm_out, sb_q[0].imm);
    end
    out_ready = 1'b1;
    tick();
    check("bp_inready_back", {31'd0, in_ready}, 32'd1);
    tick();
    check("bp_third_accepted", {31'd0, last_acc}, 32'd1);
    drain();
    check("bp_inready_end", {31'd0, in_ready}, 32'd1);

    // Flush with main and skid full, word offered in the flush cycle.
    out_ready = 1'b0;
    send(tbl[2]); send(tbl[4]);
    cur_exp = tbl[6]; instr = tbl[6].instr; in_valid = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_outvalid", {31'd0, out_valid}, 32'd0);
    check("flush_inready", {31'd0, in_ready}, 32'd1);
    drain();

    // Flush discards a word accepted in the same cycle.
    out_ready = 1'b0;
    send(tbl[7]);
    cur_exp = tbl[8]; instr = tbl[8].instr; in_valid = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_acc_outvalid", {31'd0, out_valid}, 32'd0);
    drain();

    // Handoff coinciding with flush still counts.
    out_ready = 1'b0;
    send(tbl[9]);
    out_ready = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_hs_outvalid", {31'd0, out_valid}, 32'd0);
    drain();

    // Reset with flush mid-stream.
    out_ready = 1'b0;
    send(tbl[10]); send(tbl[11]);
    rst = 1'b1; flush = 1'b1;
    tick();
    rst = 1'b0; flush = 1'b0;
    check("rst2_outvalid", {31'd0, out_valid}, 32'd0);
    check("rst2_inready", {31'd0, in_ready}, 32'd1);
    check("rst2_count", {28'd0, decode_count}, 32'd0);
    check("rst2_alu", {28'd0, alu_control}, 32'd0);
    drain();

    // Counter wrap after exactly 2^CNT_W handoffs of an illegal word.
    out_ready = 1'b1;
    for (int i = 0; i < (1 << CNT_W); i++) send(tbl[24]);
    drain();
    check("wrap_count", {28'd0, decode_count}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
